cache_line_burst_engine: RTL

- Initiator-side controller for the cache data array: the quad-port RAM with write-capable ports A/B and read-only ports C/D.
- Accepts whole-line read or write commands and streams the line through RAM ports A and B, two words per cycle.
- Read data is returned on a ready/valid stream. A 2-entry output buffer absorbs the RAM's fixed 1-cycle read latency under backpressure.
- Ports C/D are not driven by this block; they remain free for tag/hit lookups.

---
 rtl/cache_line_burst_engine.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cache_line_burst_engine.sv
// cache_line_burst_engine: moves whole cache lines between ready/valid streams and RAM ports A/B, two words per beat
module cache_line_burst_engine #(
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE = 32,
  parameter int LINE_BITS = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [ADDRESS_SPACE-LINE_BITS-1:0] cmd_line,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [2*DATA_SIZE-1:0]             wr_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [2*DATA_SIZE-1:0]             rd_data,
  output logic                               rd_last,
  output logic                               done,
  output logic [ADDRESS_SPACE-1:0]           ram_addr_a,
  output logic [ADDRESS_SPACE-1:0]           ram_addr_b,
  output logic [DATA_SIZE-1:0]               ram_data_a,
  output logic [DATA_SIZE-1:0]               ram_data_b,
  output logic                               ram_we_a,
  output logic                               ram_we_b,
  input  logic [DATA_SIZE-1:0]               ram_q_a,
  input  logic [DATA_SIZE-1:0]               ram_q_b
);
  localparam int BW = LINE_BITS - 1;
  localparam int LW = ADDRESS_SPACE - LINE_BITS;
  localparam int DW = 2 * DATA_SIZE;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic [BW-1:0] beat_q, beat_d;
  logic inflight_q, inflight_d, inlast_q, inlast_d, done_q, done_d;
  logic [1:0] count_q, count_d, blast_q, blast_d;
  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic pop, issue, last_beat;
  logic [1:0] kept;
  assign cmd_ready = state_q == IDLE;
  assign wr_ready = state_q == WRITE;
  assign rd_valid = count_q != 2'd0;
  assign rd_data = buf_q[0];
  assign rd_last = rd_valid & blast_q[0];
  assign done = done_q;
  assign ram_addr_a = cmd_ready ? '0 : {line_q, beat_q, 1'b0};
  assign ram_addr_b = cmd_ready ? '0 : {line_q, beat_q, 1'b1};
  assign ram_we_a = wr_ready & wr_valid;
  assign ram_we_b = wr_ready & wr_valid;
  assign ram_data_a = wr_ready ? wr_data[DATA_SIZE-1:0] : '0;
  assign ram_data_b = wr_ready ? wr_data[DW-1:DATA_SIZE] : '0;
  assign pop = rd_valid & rd_ready;
  assign last_beat = beat_q == '1;
  // a beat may only be issued if its data is guaranteed a buffer slot one cycle later
  assign issue = state_q == READ && ({1'b0, count_q} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
  assign kept = count_q - {1'b0, pop};
  always_comb begin
    state_d = state_q;
    line_d = line_q;
    beat_d = beat_q;
    done_d = 1'b0;
    inflight_d = issue;
    inlast_d = issue & last_beat;
    case (state_q)
      IDLE: if (cmd_valid) begin
        line_d = cmd_line;
        beat_d = '0;
        state_d = cmd_write ? WRITE : READ;
      end
      WRITE: if (wr_valid) begin
        beat_d = beat_q + 1'b1;
        state_d = last_beat ? IDLE : WRITE;
        done_d = last_beat;
      end
      READ: if (issue) begin
        beat_d = beat_q + 1'b1;
        state_d = last_beat ? DRAIN : READ;
      end
      default: if (pop & blast_q[0]) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    endcase
  end
  always_comb begin
    buf_d[0] = pop ? buf_q[1] : buf_q[0];
    buf_d[1] = buf_q[1];
    blast_d = pop ? {blast_q[1], blast_q[1]} : blast_q;
    if (inflight_q) begin
      if (kept == 2'd0) begin
        buf_d[0] = {ram_q_b, ram_q_a};
        blast_d[0] = inlast_q;
      end else begin
        buf_d[1] = {ram_q_b, ram_q_a};
        blast_d[1] = inlast_q;
      end
    end
    count_d = kept + {1'b0, inflight_q};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      line_q <= '0;
      beat_q <= '0;
      inflight_q <= 1'b0;
      inlast_q <= 1'b0;
      done_q <= 1'b0;
      count_q <= '0;
      blast_q <= '0;
      buf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      beat_q <= beat_d;
      inflight_q <= inflight_d;
      inlast_q <= inlast_d;
      done_q <= done_d;
      count_q <= count_d;
      blast_q <= blast_d;
      buf_q <= buf_d;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(inflight_q && count_q == 2'd2));
endmodule
